// File: rtl/pipe_stage.sv
// Two-entry skid buffer between pipeline stages.
// Registered ready/valid with flush; head entry drives the outputs.
module pipe_stage #(
  parameter int DATA_WIDTH = 160,
  parameter int CWORD_WIDTH = 31,
  parameter int DEST_WIDTH = 3,
  parameter logic [CWORD_WIDTH-1:0] NOP_CWORD = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            pc_in,
  input  logic [CWORD_WIDTH-1:0] cword_in,
  input  logic [DEST_WIDTH-1:0]  dest_in,
  input  logic [DATA_WIDTH-1:0]  data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            pc_out,
  output logic [CWORD_WIDTH-1:0] cword_out,
  output logic [DEST_WIDTH-1:0]  dest_out,
  output logic [DATA_WIDTH-1:0]  data_out
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t state;

  logic [15:0]            skid_pc;
  logic [CWORD_WIDTH-1:0] skid_cword;
  logic [DEST_WIDTH-1:0]  skid_dest;
  logic [DATA_WIDTH-1:0]  skid_data;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      pc_out     <= '0;
      cword_out  <= NOP_CWORD;
      dest_out   <= '0;
      data_out   <= '0;
      skid_pc    <= '0;
      skid_cword <= NOP_CWORD;
      skid_dest  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      // Only our own entries die; a same-cycle pop was still taken.
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cword_out <= NOP_CWORD;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            pc_out    <= pc_in;
            cword_out <= cword_in;
            dest_out  <= dest_in;
            data_out  <= data_in;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            pc_out    <= pc_in;
            cword_out <= cword_in;
            dest_out  <= dest_in;
            data_out  <= data_in;
          end else if (in_fire) begin
            skid_pc    <= pc_in;
            skid_cword <= cword_in;
            skid_dest  <= dest_in;
            skid_data  <= data_in;
            in_ready   <= 1'b0;
            state      <= TWO;
          end else if (out_fire) begin
            out_valid <= 1'b0;
            cword_out <= NOP_CWORD;
            state     <= EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            pc_out    <= skid_pc;
            cword_out <= skid_cword;
            dest_out  <= skid_dest;
            data_out  <= skid_data;
            in_ready  <= 1'b1;
            state     <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          cword_out <= NOP_CWORD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: directed scenarios plus random traffic
// against a queue model of the two-entry buffer.
module tb_pipe_stage;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic         in_ready, out_valid;
  logic [15:0]  pc_in, pc_out;
  logic [30:0]  cword_in, cword_out;
  logic [2:0]   dest_in, dest_out;
  logic [159:0] data_in, data_out;

  logic         iv8, ir8, ov8;
  logic [15:0]  pco8;
  logic [3:0]   cw8, cwo8;
  logic [2:0]   dsto8;
  logic [7:0]   d8, do8;

  always #5 clk = ~clk;

  pipe_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .cword_in(cword_in),
    .dest_in(dest_in), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .cword_out(cword_out),
    .dest_out(dest_out), .data_out(data_out)
  );

  pipe_stage #(
    .DATA_WIDTH(8), .CWORD_WIDTH(4), .NOP_CWORD(4'hF)
  ) dut8 (
    .clk(clk), .reset(reset), .flush(1'b0),
    .in_valid(iv8), .in_ready(ir8),
    .pc_in(16'h0), .cword_in(cw8),
    .dest_in(3'h0), .data_in(d8),
    .out_valid(ov8), .out_ready(1'b1),
    .pc_out(pco8), .cword_out(cwo8),
    .dest_out(dsto8), .data_out(do8)
  );

  typedef struct packed {
    logic [15:0]  pc;
    logic [30:0]  cw;
    logic [2:0]   dest;
    logic [159:0] data;
  } ent_t;

  ent_t q[$];
  ent_t hold;
  int   pass = 0;
  int   total = 0;
  bit   chk_en = 0;

  task automatic chk(string nm, logic [159:0] act, logic [159:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h, expected %0h @%0t", nm, act, exp, $time);
  endtask

  // Reference: a FIFO of at most two entries.
  always @(posedge clk) begin
    bit   inf, outf;
    ent_t e;
    if (reset) begin
      q.delete();
      hold = '0;
    end else begin
      inf  = in_valid && (q.size() < 2);
      outf = out_ready && (q.size() > 0);
      e    = '{pc: pc_in, cw: cword_in, dest: dest_in, data: data_in};
      if (flush) q.delete();
      else begin
        if (outf) void'(q.pop_front());
        if (inf) q.push_back(e);
      end
      if (q.size() > 0) hold = q[0];
    end
  end

  always @(negedge clk) begin
    ent_t cur;
    if (chk_en) begin
      chk("out_valid", 160'(out_valid), 160'(q.size() > 0));
      chk("in_ready", 160'(in_ready), 160'(q.size() < 2));
      if (q.size() > 0) cur = q[0];
      else begin
        cur = hold;
        cur.cw = '0;
      end
      chk("pc_out", 160'(pc_out), 160'(cur.pc));
      chk("cword_out", 160'(cword_out), 160'(cur.cw));
      chk("dest_out", 160'(dest_out), 160'(cur.dest));
      chk("data_out", data_out, cur.data);
    end
  end

  task automatic cyc(bit iv, logic [15:0] pc, bit ordy, bit fl, bit rs);
    in_valid  = iv;
    pc_in     = pc;
    cword_in  = 31'($urandom);
    dest_in   = 3'($urandom);
    data_in   = {$urandom, $urandom, $urandom, $urandom, $urandom};
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
    @(negedge clk);
  endtask

  task automatic exp(string nm, bit v, bit r, logic [15:0] pc);
    chk({nm, ".valid"}, 160'(out_valid), 160'(v));
    chk({nm, ".ready"}, 160'(in_ready), 160'(r));
    chk({nm, ".pc"}, 160'(pc_out), 160'(pc));
  endtask

  initial begin
    iv8 = 1'b0;
    cw8 = 4'h0;
    d8  = 8'h00;
    cyc(0, 16'h0, 0, 0, 1);
    chk_en = 1;
    exp("reset", 0, 1, 16'h0);
    chk("reset.cword", 160'(cword_out), 160'(0));
    chk("reset.data", data_out, 160'(0));
    chk("reset.dest", 160'(dest_out), 160'(0));
    chk("p8.idle_cword", 160'(cwo8), 160'(4'hF));
    chk("p8.idle_valid", 160'(ov8), 160'(0));

    iv8 = 1'b1; cw8 = 4'h3; d8 = 8'hA5;
    cyc(0, 16'h0, 1, 0, 0);
    exp("idle", 0, 1, 16'h0);
    chk("p8.data", 160'(do8), 160'(8'hA5));
    chk("p8.cword", 160'(cwo8), 160'(4'h3));
    chk("p8.valid", 160'(ov8), 160'(1));
    iv8 = 1'b0;
    cyc(0, 16'h0, 1, 0, 0);
    chk("p8.drain_cword", 160'(cwo8), 160'(4'hF));
    chk("p8.drain_data", 160'(do8), 160'(8'hA5));

    cyc(1, 16'h1000, 1, 0, 0); exp("stream0", 1, 1, 16'h1000);
    cyc(1, 16'h1002, 1, 0, 0); exp("stream1", 1, 1, 16'h1002);
    cyc(1, 16'h1004, 1, 0, 0); exp("stream2", 1, 1, 16'h1004);
    cyc(0, 16'h0, 1, 0, 0);    exp("stream_end", 0, 1, 16'h1004);

    cyc(1, 16'h2000, 0, 0, 0); exp("bp_push0", 1, 1, 16'h2000);
    cyc(1, 16'h2002, 0, 0, 0); exp("bp_push1", 1, 0, 16'h2000);
    cyc(0, 16'h0, 0, 0, 0);    exp("bp_stall", 1, 0, 16'h2000);
    cyc(0, 16'h0, 1, 0, 0);    exp("bp_pop0", 1, 1, 16'h2002);
    cyc(0, 16'h0, 1, 0, 0);    exp("bp_pop1", 0, 1, 16'h2002);

    cyc(1, 16'h2100, 0, 0, 0);
    cyc(1, 16'h2102, 0, 0, 0); exp("fl_full", 1, 0, 16'h2100);
    cyc(1, 16'h3000, 0, 1, 0); exp("flush", 0, 1, 16'h2100);
    chk("flush.cword", 160'(cword_out), 160'(0));
    cyc(0, 16'h0, 1, 0, 0);    exp("flush_after", 0, 1, 16'h2100);

    cyc(1, 16'h4000, 0, 0, 0);
    cyc(1, 16'h4002, 0, 0, 0); exp("rs_full", 1, 0, 16'h4000);
    cyc(0, 16'h0, 1, 0, 1);    exp("rs_mid", 0, 1, 16'h0);
    cyc(1, 16'h4100, 0, 0, 0); exp("rs_push", 1, 1, 16'h4100);
    cyc(0, 16'h0, 1, 0, 0);    exp("rs_drain", 0, 1, 16'h4100);

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 65, 16'($urandom),
          $urandom_range(0, 99) < 60,
          $urandom_range(0, 99) < 5, 0);
    end
    cyc(0, 16'h0, 1, 0, 0);
    cyc(0, 16'h0, 1, 0, 0);
    cyc(0, 16'h0, 1, 0, 0);
    chk_en = 0;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
